arb_mux_sched: RTL
==================

ARB_MUX_SCHED -- requirements
Module: arb_mux_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 12, word width; bits [DATA_W-1:DATA_W-2] carry the lane ID (0..3).
REQ-002 SHALL have parameter ERR_W, default 8, error-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid  input  4  per-lane word valid, bit i = lane i.
REQ-006 SHALL have ports data_in0..data_in3  input  DATA_W each  per-lane word.
REQ-007 SHALL have port in_ready  output  4  per-lane accept strobe, combinational.
REQ-008 SHALL have port data_out  output  DATA_W  registered granted word.
REQ-009 SHALL have port out_valid  output  1  data_out holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts data_out.
REQ-011 SHALL have port grant_id  output  2  lane of the word in data_out.
REQ-012 SHALL have port err_count  output  ERR_W  ID-mismatch drop count.

Function
REQ-013 SHALL hold one output register slot; load_en = !out_valid | out_ready.
REQ-014 SHALL arbitrate round-robin: search lanes starting at (last_grant+1) mod 4, wrapping, first lane with in_valid set wins.
REQ-015 SHALL assert in_ready[winner] only when load_en=1 and a winner exists; all other in_ready bits 0; at most one bit set.
REQ-016 SHALL on transfer (in_valid[i] & in_ready[i]) load data_out<=data_in i, grant_id<=i, out_valid<=1, last_grant<=i next edge; latency exactly 1 cycle.
REQ-017 SHALL clear out_valid on out_ready=1 with no new transfer that cycle.
REQ-018 SHALL on out_ready=1 and a new transfer in the same cycle replace data_out with no bubble (full throughput, one word/cycle).
REQ-019 SHALL hold data_out, grant_id, out_valid stable while out_valid=1 and out_ready=0 (backpressure); in_ready all 0 then.
REQ-020 SHALL update last_grant only on a transfer; no request leaves pointer unchanged.
REQ-021 SHALL treat an all-zero data word with in_valid=1 as a normal word (valid alone qualifies data).
REQ-022 SHALL guarantee any continuously valid lane is granted within 4 transfers (no starvation).
REQ-023 SHALL keep in_ready combinationally independent of data contents.

Reset
REQ-024 SHALL on reset=1 at a clock edge set data_out=0, out_valid=0, grant_id=0, last_grant=3 (lane 0 first priority), err_count=0.
REQ-025 SHALL force in_ready=0 while reset=1; a word held in the slot mid-operation is discarded.
REQ-026 SHALL resume arbitration on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro ARB_MUX_ID_CHECK_EN defined, drop a granted word whose ID field != its lane index: in_ready still asserted (word consumed), slot not loaded, last_grant updated, err_count incremented, saturating at all-ones.
REQ-028 SHALL, without ARB_MUX_ID_CHECK_EN, pass all words regardless of ID field and tie err_count to 0.

Verification
REQ-029 SHALL cover: reset then in_valid=4'b1111, out_ready=1 held, lane i data = {i[1:0],10'h00A+i} -> grant order 0,1,2,3,0 on consecutive cycles, out_valid=1 from cycle 1.
REQ-030 SHALL cover: single lane 2 word 12'h805, out_ready=0 for 3 cycles -> data_out=12'h805, grant_id=2 stable, in_ready=0 throughout; accepted on out_ready=1, out_valid=0 next cycle.
REQ-031 SHALL cover: lane 1 valid with 12'h400 while last_grant=1, lane 3 valid -> lane 3 granted first, lane 1 next.
REQ-032 SHALL cover: reset asserted with out_valid=1, data_out=12'hC07 -> next edge out_valid=0, data_out=0, in_ready=0 during reset.
REQ-033 SHALL cover: with ARB_MUX_ID_CHECK_EN, lane 0 sends 12'h401 (ID 1) -> in_ready[0]=1, out_valid stays 0, err_count 0->1; 300 bad words with ERR_W=8 -> err_count=8'hFF; without macro same word appears on data_out, err_count=0.

Source files
------------

// File: rtl/arb_mux_sched.sv
// ============================================================================
// Module   : arb_mux_sched
// Purpose  : 4-lane round-robin arbiter and mux into a single registered
//            output slot with valid/ready handshake.
// Optional : ARB_MUX_ID_CHECK_EN enables dropping of words whose ID field
//            does not match their lane, counted in err_count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_mux_sched #(
  parameter int DATA_W = 12,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant_id,
  output logic [ERR_W-1:0]  err_count
);

  logic [1:0]        last_grant;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic              found;
  logic              load_en;
  logic              transfer;
  logic              id_ok;
  logic [DATA_W-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  // Rotating search: offset 4 wraps back to last_grant itself, so the lane
  // granted last has the lowest priority next time.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!reset && load_en && found) begin
      in_ready[winner] = 1'b1;
    end
  end

  assign transfer = !reset && load_en && found;

  always_comb begin
    case (winner)
      2'd0:    sel_data = data_in0;
      2'd1:    sel_data = data_in1;
      2'd2:    sel_data = data_in2;
      default: sel_data = data_in3;
    endcase
  end

`ifdef ARB_MUX_ID_CHECK_EN
  assign id_ok = (sel_data[DATA_W-1 -: 2] == winner);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (transfer && !id_ok && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign id_ok     = 1'b1;
  assign err_count = '0;
`endif

  // A dropped word still consumes its lane and advances the pointer, but
  // the slot behaves as if no new word arrived.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
    end else if (transfer) begin
      last_grant <= winner;
      if (id_ok) begin
        data_out  <= sel_data;
        grant_id  <= winner;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
